data_memory_unit: RTL and testbench

//   Parametrised byte-addressable data memory for the MEM stage of the 5-stage pipeline.

---
 rtl/data_memory_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_data_memory_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// -----------------------------------------------------------------------------
// data_memory_unit
//
// Byte-addressable data memory for the MEM stage of a 5-stage RV32I pipeline.
// It handles byte, halfword and word loads/stores (signed and unsigned loads)
// with little-endian byte lanes. The read port is registered: every accepted
// request produces exactly one response pulse on the following cycle.
// After reset the contents are zeroed by a hardware sweep of 4 bytes/cycle.
// Misaligned halfword/word accesses and illegal funct3 codes are flagged
// through the fault output and leave the memory untouched.
//
// Parameters
//   DEPTH_BYTES : memory size in bytes (power of two, >= 4)
//   ADDR_W      : width of the byte address port
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   req_valid  : request present this cycle
//   req_ready  : block can accept a request this cycle
//   mem_write  : 1 = store, 0 = load
//   funct3     : RV32I size/sign code
//   address    : byte address (upper bits beyond the memory size are ignored)
//   write_data : store data, lane-aligned from bit 0
//   read_data  : load result, sign/zero extended; holds until the next response
//   rsp_valid  : one-cycle pulse answering the request accepted last cycle
//   fault      : qualifies rsp_valid, misaligned access or illegal funct3
//   busy       : clear sweep in progress
// -----------------------------------------------------------------------------
module data_memory_unit #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              rsp_valid,
    output logic              fault,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Control state and registered outputs
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clear_ptr_q, clear_ptr_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              fault_q, fault_d;
    logic              busy_q, busy_d;
    logic [31:0]       read_data_q, read_data_d;

    // Storage: no reset, contents are zeroed by the clear sweep instead
    logic [7:0]        mem_q [DEPTH_BYTES];

    // Request decode
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              legal_f3;
    logic              misaligned;
    logic              req_fault;
    logic              do_store;
    logic              do_clear;
    logic [3:0]        lane_we;
    logic [31:0]       raw_word;

    // Address bits above the memory size wrap silently.
    generate
        if (ADDR_W > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[ADDR_W-1:IDX_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
    // -------------------------------------------------------------------------
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [31:0] raw);
        logic [31:0] res;
        case (f3)
            3'b000:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b010:  res = raw;
            3'b100:  res = {24'h000000, raw[7:0]};
            3'b101:  res = {16'h0000, raw[15:0]};
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

    always_comb begin
        idx    = address[IDX_W-1:0];
        accept = req_valid & req_ready_q;

        legal_f3 = 1'b0;
        if (mem_write) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
                default:                legal_f3 = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101:         legal_f3 = 1'b1;
                default:                legal_f3 = 1'b0;
            endcase
        end

        // funct3[1:0] encodes the access size for every legal code
        misaligned = ((funct3[1:0] == 2'b01) & idx[0]) |
                     ((funct3[1:0] == 2'b10) & (idx[1:0] != 2'b00));
        req_fault  = ~legal_f3 | misaligned;

        // Reset wins over any memory update in the same cycle
        do_store = accept & mem_write & ~req_fault & ~reset;
        do_clear = (state_q == ST_CLEAR) & ~reset;

        case (funct3[1:0])
            2'b00:   lane_we = 4'b0001;
            2'b01:   lane_we = 4'b0011;
            2'b10:   lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
        if (!do_store) begin
            lane_we = 4'b0000;
        end

        // Lanes beyond the access size may wrap past the end; they are
        // discarded by load_extend, and alignment keeps used lanes in range.
        for (int k = 0; k < 4; k++) begin
            raw_word[8*k +: 8] = mem_q[idx + IDX_W'(k)];
        end
    end

    // -------------------------------------------------------------------------
    // Memory write port: the clear sweep and stores are mutually exclusive
    // because stores are only accepted in READY.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_clear) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[clear_ptr_q + IDX_W'(k)] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (lane_we[k]) begin
                    mem_q[idx + IDX_W'(k)] <= write_data[8*k +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic for the FSM and registered outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        rsp_valid_d = 1'b0;
        fault_d     = 1'b0;
        read_data_d = read_data_q;

        case (state_q)
            ST_CLEAR: begin
                clear_ptr_d = clear_ptr_q + IDX_W'(4);
                if (clear_ptr_q == IDX_W'(DEPTH_BYTES - 4)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    fault_d     = req_fault;
                    // Store and faulted responses return zero data
                    if (req_fault || mem_write) begin
                        read_data_d = 32'h00000000;
                    end else begin
                        read_data_d = load_extend(funct3, raw_word);
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        req_ready_d = (state_d == ST_READY);
        busy_d      = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            read_data_q <= 32'h00000000;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
            read_data_q <= read_data_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign fault     = fault_q;
    assign read_data = read_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// -----------------------------------------------------------------------------
// tb_data_memory_unit
//
// Self-checking bench for data_memory_unit (DEPTH_BYTES=1024, ADDR_W=32).
// Directed steps follow the load/store scenarios of the block, then a run of
// random requests is checked against a byte-array reference model, then reset
// is exercised mid-load and mid-sweep and the whole memory is read back.
// -----------------------------------------------------------------------------
module tb_data_memory_unit;

    localparam int DEPTH = 1024;
    localparam int SWEEP = DEPTH / 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        rsp_valid;
    logic        fault;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    byte unsigned model_mem [DEPTH];
    logic [31:0]  last_rd;
    logic [31:0]  obs_rd;

    data_memory_unit #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .rsp_valid  (rsp_valid),
        .fault      (fault),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: apply one request to the byte array and return the
    // response the block should give.
    task automatic model_access(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic exp_fault, output logic [31:0] exp_rd);
        int     size;
        int     base;
        bit     legal;
        longint v;
        case (f3 % 4)
            0:       size = 1;
            1:       size = 2;
            2:       size = 4;
            default: size = 8;
        endcase
        if (we) legal = (f3 <= 2);
        else    legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
        base      = int'(addr % DEPTH);
        exp_fault = !legal || ((base % size) != 0);
        exp_rd    = 32'h0;
        if (!exp_fault) begin
            if (we) begin
                for (int k = 0; k < size; k++)
                    model_mem[base + k] = byte'(wd >> (8 * k));
            end else begin
                v = 0;
                for (int k = 0; k < size; k++)
                    v = v + (longint'(model_mem[base + k]) << (8 * k));
                if (f3 < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v = v - (longint'(1) << (8 * size));
                exp_rd = v[31:0];
            end
        end
    endtask

    // Issue one request, wait for the accepting edge, check the response.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        ef;
        logic [31:0] ed;
        model_access(we, f3, addr, wd, ef, ed);
        req_valid  = 1'b1;
        mem_write  = we;
        funct3     = f3;
        address    = addr;
        write_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".fault"},     32'(fault),     32'(ef));
        chk({tag, ".read_data"}, read_data,      ed);
        obs_rd  = read_data;
        last_rd = ed;
    endtask

    // Count cycles until busy drops; bounded. Requests are held valid
    // throughout to prove they are ignored during the sweep.
    task automatic sweep(output int cyc, output int bad);
        cyc = 0;
        bad = 0;
        req_valid  = 1'b1;
        mem_write  = 1'b1;
        funct3     = 3'b010;
        address    = 32'h10;
        write_data = 32'hFFFF_FFFF;
        while (busy && cyc < 2000) begin
            if (req_ready || rsp_valid) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        if (rsp_valid) bad++;
    endtask

    initial begin
        int          cyc;
        int          bad;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        reset = 1'b1; req_valid = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; address = 32'h0; write_data = 32'h0;
        last_rd = 32'h0; obs_rd = 32'h0;

        // Reset state
        @(posedge clk); #1;
        chk("rst.busy",      32'(busy),      32'd1);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.fault",     32'(fault),     32'd0);
        chk("rst.read_data", read_data,      32'h0);
        reset = 1'b0;

        sweep(cyc, bad);
        chk("sweep1.cycles",    32'(cyc),       32'(SWEEP));
        chk("sweep1.ignored",   32'(bad),       32'd0);
        chk("sweep1.req_ready", 32'(req_ready), 32'd1);

        // Top word and the address targeted during the sweep read zero
        do_req("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0);
        chk("lw3fc.const", obs_rd, 32'h0000_0000);
        do_req("lw010", 1'b0, 3'b010, 32'h010, 32'h0);

        // Store then load on consecutive cycles
        do_req("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        do_req("lw100", 1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw100.const", obs_rd, 32'hDEADBEEF);

        do_req("sb101",  1'b1, 3'b000, 32'h101, 32'h0000_0080);
        do_req("lb101",  1'b0, 3'b000, 32'h101, 32'h0);
        chk("lb101.const", obs_rd, 32'hFFFF_FF80);
        do_req("lbu101", 1'b0, 3'b100, 32'h101, 32'h0);
        chk("lbu101.const", obs_rd, 32'h0000_0080);
        do_req("lw100b", 1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw100b.const", obs_rd, 32'hDEAD80EF);

        // Response pulse lasts one cycle; read_data holds
        @(posedge clk); #1;
        chk("idle.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle.fault",     32'(fault),     32'd0);
        chk("idle.read_data", read_data,      last_rd);

        // Faults: misaligned half/word, illegal funct3 for load and store
        do_req("sh103",   1'b1, 3'b001, 32'h103, 32'h0000_5555);
        do_req("lw102",   1'b0, 3'b010, 32'h102, 32'h0);
        do_req("ld011",   1'b0, 3'b011, 32'h100, 32'h0);
        do_req("st100",   1'b1, 3'b100, 32'h100, 32'h1111_1111);
        do_req("sw102",   1'b1, 3'b010, 32'h102, 32'h2222_2222);
        do_req("lw100c",  1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw100c.const", obs_rd, 32'hDEAD80EF);
        do_req("lh102",   1'b0, 3'b001, 32'h102, 32'h0);
        chk("lh102.const", obs_rd, 32'hFFFF_DEAD);
        do_req("lhu102",  1'b0, 3'b101, 32'h102, 32'h0);
        chk("lhu102.const", obs_rd, 32'h0000_DEAD);

        // Address wrap
        do_req("sw404", 1'b1, 3'b010, 32'h0000_0404, 32'h1234_5678);
        do_req("lw004", 1'b0, 3'b010, 32'h0000_0004, 32'h0);
        chk("lw004.const", obs_rd, 32'h1234_5678);

        // Top byte of memory
        do_req("sb3ff", 1'b1, 3'b000, 32'h3FF, 32'h0000_00A5);
        do_req("lb3ff", 1'b0, 3'b000, 32'h3FF, 32'h0);

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'h3;
            do_req($sformatf("rnd%0d", i), we, f3, addr, $urandom);
        end

        // Reset together with a load: no response follows
        req_valid = 1'b1; mem_write = 1'b0; funct3 = 3'b010; address = 32'h100;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        chk("rstld.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstld.busy",      32'(busy),      32'd1);
        chk("rstld.read_data", read_data,      32'h0);

        // Reset again 100 cycles into the sweep; sweep restarts from scratch
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstmid.busy", 32'(busy), 32'd1);
        sweep(cyc, bad);
        chk("sweep2.cycles",  32'(cyc), 32'(SWEEP));
        chk("sweep2.ignored", 32'(bad), 32'd0);

        // Everything reads zero afterwards
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        for (int w = 0; w < SWEEP; w++) begin
            do_req($sformatf("clr%0d", w), 1'b0, 3'b010, 32'(w * 4), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
